// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package pipelined_cla_adder_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_BLOCK = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // One lookahead group is resolved per pipeline stage.
   function automatic int unsigned calc_nstg(input int unsigned width, input int unsigned block);
      return width / block;
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle; master drives operands, slave is the adder.
interface pipelined_cla_adder_if
   import pipelined_cla_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );

endinterface

// File: rtl/pipelined_cla_adder_cla_block.sv
// Combinational BLOCK-bit lookahead group: sum, group propagate/generate and carries.
module cla_block
   import pipelined_cla_adder_pkg::*;
#(
   parameter int unsigned BLOCK = DEF_BLOCK
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             c,
   output logic [BLOCK-1:0] s,
   output logic             grp_p,
   output logic             grp_g,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [BLOCK-1:0] p;
   logic [BLOCK-1:0] g;
   logic [BLOCK:0]   cv;

   // Bit carries unroll into flat lookahead terms; group G ignores the incoming carry.
   always_comb begin
      p     = a ^ b;
      g     = a & b;
      cv    = '0;
      cv[0] = c;
      grp_g = 1'b0;
      for (int i = 0; i < int'(BLOCK); i++) begin
         cv[i+1] = g[i] | (p[i] & cv[i]);
         grp_g   = g[i] | (p[i] & grp_g);
      end
      s        = p ^ cv[BLOCK-1:0];
      grp_p    = &p;
      c_out    = cv[BLOCK];
      c_msb_in = cv[BLOCK-1];
   end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one lookahead group per stage, global-stall handshake.
module pipelined_cla_adder
   import pipelined_cla_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned BLOCK = DEF_BLOCK
) (
   input logic                  clk,
   input logic                  rst,
   pipelined_cla_adder_if.slave bus
);

   localparam int unsigned NSTG = calc_nstg(WIDTH, BLOCK);

   // Stage inputs (combinational view of what enters each stage)
   logic [WIDTH-1:0] stg_a   [NSTG];
   logic [WIDTH-1:0] stg_b   [NSTG];
   logic [WIDTH-1:0] stg_sum [NSTG];
   logic             stg_c   [NSTG];
   logic             stg_vld [NSTG];

   logic [BLOCK-1:0] blk_s    [NSTG];
   logic             blk_p    [NSTG];
   logic             blk_g    [NSTG];
   logic             blk_cout [NSTG];
   logic             blk_cmsb [NSTG];

   logic [WIDTH-1:0] a_d   [NSTG], a_q   [NSTG];
   logic [WIDTH-1:0] b_d   [NSTG], b_q   [NSTG];
   logic [WIDTH-1:0] sum_d [NSTG], sum_q [NSTG];
   logic             c_d   [NSTG], c_q   [NSTG];
   logic             vld_d [NSTG], vld_q [NSTG];
   logic             cout_d, cout_q;
   logic             ovf_d,  ovf_q;
   logic             zero_d, zero_q;

   logic             adv;

   assign adv          = bus.out_ready | ~vld_q[NSTG-1];
   assign bus.in_ready = adv;

   // Stage 0 sees the effective operands; later stages see the previous stage's registers.
   always_comb begin
      stg_a[0]   = bus.a;
      stg_b[0]   = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
      stg_c[0]   = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;
      stg_sum[0] = '0;
      stg_vld[0] = bus.in_valid;
      for (int k = 1; k < int'(NSTG); k++) begin
         stg_a[k]   = a_q[k-1];
         stg_b[k]   = b_q[k-1];
         stg_c[k]   = c_q[k-1];
         stg_sum[k] = sum_q[k-1];
         stg_vld[k] = vld_q[k-1];
      end
   end

   for (genvar k = 0; k < int'(NSTG); k++) begin : g_stg
      cla_block #(.BLOCK(BLOCK)) u_cla (
         .a        (stg_a[k][k*BLOCK +: BLOCK]),
         .b        (stg_b[k][k*BLOCK +: BLOCK]),
         .c        (stg_c[k]),
         .s        (blk_s[k]),
         .grp_p    (blk_p[k]),
         .grp_g    (blk_g[k]),
         .c_out    (blk_cout[k]),
         .c_msb_in (blk_cmsb[k])
      );
   end

   // Whole pipeline shifts on adv and holds otherwise; flags come from the last group.
   always_comb begin
      for (int k = 0; k < int'(NSTG); k++) begin
         a_d[k]   = a_q[k];
         b_d[k]   = b_q[k];
         sum_d[k] = sum_q[k];
         c_d[k]   = c_q[k];
         vld_d[k] = vld_q[k];
      end
      cout_d = cout_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
      if (adv) begin
         for (int k = 0; k < int'(NSTG); k++) begin
            a_d[k]   = stg_a[k];
            b_d[k]   = stg_b[k];
            c_d[k]   = blk_g[k] | (blk_p[k] & stg_c[k]);
            vld_d[k] = stg_vld[k];
            sum_d[k] = stg_sum[k];
            sum_d[k][k*BLOCK +: BLOCK] = blk_s[k];
         end
         cout_d = blk_cout[NSTG-1];
         ovf_d  = blk_cmsb[NSTG-1] ^ blk_cout[NSTG-1];
         zero_d = (sum_d[NSTG-1] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(NSTG); k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
            c_q[k]   <= 1'b0;
            vld_q[k] <= 1'b0;
         end
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         for (int k = 0; k < int'(NSTG); k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
            c_q[k]   <= c_d[k];
            vld_q[k] <= vld_d[k];
         end
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign bus.out_valid = vld_q[NSTG-1];
   assign bus.sum       = sum_q[NSTG-1];
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: 32-bit streaming instance plus an 8-bit instance.
module tb_pipelined_cla_adder;
   import pipelined_cla_adder_pkg::*;

   localparam int W     = 32;
   localparam int NSTG  = 8;
   localparam int W8    = 8;
   localparam int NSTG8 = 2;

   typedef struct {
      logic [W-1:0] sum;
      logic [2:0]   flg;   // {cout, ovf, zero}
      int           t;
      bit           lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_cla_adder_if #(.WIDTH(W))  bus  ();
   pipelined_cla_adder_if #(.WIDTH(W8)) bus8 ();

   pipelined_cla_adder #(.WIDTH(W), .BLOCK(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   pipelined_cla_adder #(.WIDTH(W8), .BLOCK(4)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   exp_t sb[$];
   exp_t cur_exp;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   bit   took;
   bit   in_stall = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      logic [W-1:0] bb;
      logic [W:0]   full;
      exp_t         e;
      bb    = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
      e.sum = full[W-1:0];
      e.flg = {full[W], (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]), full[W-1:0] == '0};
      e.t   = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] s, input logic [2:0] f);
      exp_t e;
      e.sum = s;
      e.flg = f;
      e.t   = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   // One cycle: sample at negedge, score outputs, record accepted inputs, advance.
   task automatic step();
      exp_t e;
      took = 1'b0;
      @(negedge clk);
      if (!rst) begin
         if (in_stall) begin
            check_eq("in_ready_stall", 64'(bus.in_ready), 64'(0));
            check_eq("out_valid_stall", 64'(bus.out_valid), 64'(1));
         end
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check_eq("spurious_out", 64'(bus.out_valid), 64'(0));
            end else begin
               check_eq("sum", 64'(bus.sum), 64'(sb[0].sum));
               check_eq("flags", 64'({bus.cout, bus.ovf, bus.zero}), 64'(sb[0].flg));
               if (bus.out_ready) begin
                  e = sb.pop_front();
                  if (e.lat) check_eq("latency", 64'(cyc - e.t), 64'(NSTG));
               end
            end
         end else if (sb.size() > 0 && sb[0].lat && (cyc - sb[0].t) >= NSTG) begin
            check_eq("out_valid_missing", 64'(bus.out_valid), 64'(1));
         end
         if (bus.in_valid && bus.in_ready) begin
            e     = cur_exp;
            e.t   = cyc;
            e.lat = 1'b1;
            sb.push_back(e);
            took = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_accept();
      int n = 0;
      step();
      n++;
      while (!took && n < 64) begin
         step();
         n++;
      end
      check_eq("accept", 64'(took), 64'(1));
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      bus.in_valid = 1'b1;
      cur_exp      = e;
   endtask

   task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input exp_t e);
      drive(a, b, cin, sub, e);
      wait_accept();
   endtask

   task automatic rand_beat();
      logic [W-1:0] a, b;
      logic         cin, sub;
      a   = W'($urandom());
      b   = W'($urandom());
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      beat(a, b, cin, sub, model(a, b, cin, sub));
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic drain();
      int n = 0;
      bus.in_valid = 1'b0;
      while (sb.size() > 0 && n < 100) begin
         step();
         n++;
      end
      check_eq("drain", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W8-1:0] a8 [3];
      logic [W8-1:0] b8 [3];
      logic          s8 [3];
      logic [W8-1:0] es8 [3];
      logic [2:0]    ef8 [3];
      int            t;

      rst = 1'b1;
      bus.in_valid  = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = OP_ADD;
      bus.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = OP_ADD;
      bus8.out_ready = 1'b1;
      cur_exp = mk('0, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check_eq("rst_sum", 64'(bus.sum), 64'(0));
      check_eq("rst_flags", 64'({bus.cout, bus.ovf, bus.zero}), 64'(0));
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'(1));
      check_eq("rst8_out_valid", 64'(bus8.out_valid), 64'(0));

      // Directed vectors
      beat(32'h0000_0005, 32'h0000_0003, 1'b1, OP_ADD, mk(32'h0000_0009, 3'b000));
      idle(NSTG + 2);
      beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, mk(32'h0000_0000, 3'b101));
      beat(32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, mk(32'h7FFF_FFFF, 3'b110));
      beat(32'h0000_0003, 32'h0000_0005, 1'b1, OP_SUB, mk(32'hFFFF_FFFE, 3'b000));
      drain();

      // Back-to-back random stream
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) rand_beat();

      // Backpressure mid-stream: queued beats get delayed, so drop their latency check
      for (int i = 0; i < sb.size(); i++) sb[i].lat = 1'b0;
      begin
         logic [W-1:0] a, b;
         a = W'($urandom());
         b = W'($urandom());
         drive(a, b, 1'b1, OP_ADD, model(a, b, 1'b1, OP_ADD));
      end
      bus.out_ready = 1'b0;
      in_stall = 1'b1;
      repeat (5) step();
      in_stall = 1'b0;
      bus.out_ready = 1'b1;
      wait_accept();
      for (int i = 0; i < 6; i++) rand_beat();
      drain();

      // Bubbles: alternating valid/idle
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) rand_beat();
         else idle(1);
      end
      drain();

      // Reset with four beats in flight; none may surface afterwards
      for (int i = 0; i < 4; i++) rand_beat();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      check_eq("midrst_out_valid", 64'(bus.out_valid), 64'(0));
      check_eq("midrst_in_ready", 64'(bus.in_ready), 64'(1));
      idle(NSTG + 4);
      beat(32'h0000_0005, 32'h0000_0003, 1'b1, OP_ADD, mk(32'h0000_0009, 3'b000));
      drain();

      // 8-bit instance (two stages)
      a8[0] = 8'h05; b8[0] = 8'h03; s8[0] = OP_ADD; es8[0] = 8'h09; ef8[0] = 3'b000;
      a8[1] = 8'hFF; b8[1] = 8'h01; s8[1] = OP_ADD; es8[1] = 8'h00; ef8[1] = 3'b101;
      a8[2] = 8'h80; b8[2] = 8'h01; s8[2] = OP_SUB; es8[2] = 8'h7F; ef8[2] = 3'b110;
      for (int i = 0; i < 3; i++) begin
         bus8.a = a8[i];
         bus8.b = b8[i];
         bus8.cin = (i == 0) ? 1'b1 : 1'b0;
         bus8.sub = s8[i];
         bus8.in_valid = 1'b1;
         @(negedge clk);
         check_eq("w8_in_ready", 64'(bus8.in_ready), 64'(1));
         @(posedge clk);
         #1;
         bus8.in_valid = 1'b0;
         t = 1;
         while (!bus8.out_valid && t < 10) begin
            @(posedge clk);
            #1;
            t++;
         end
         check_eq("w8_latency", 64'(t), 64'(NSTG8));
         check_eq("w8_sum", 64'(bus8.sum), 64'(es8[i]));
         check_eq("w8_flags", 64'({bus8.cout, bus8.ovf, bus8.zero}), 64'(ef8[i]));
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
